// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit for the E stage.
// Owns HI/LO. It latches the operands on issue, counts down a fixed
// latency and commits the result to HI/LO on the final edge. mthi/mtlo
// write HI/LO directly without going busy.
module mdu_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  // Operation captured at issue; the result is computed from this copy
  // so the forwarded operands may change freely while busy.
  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } md_req_t;

  md_req_t          req_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic is_md, is_div, is_mt, accept, mt_write, done;

  // Issue decode: only an idle unit accepts anything.
  always_comb begin
    is_md    = (md_op >= OP_MULT) && (md_op <= OP_MSUBU);
    is_div   = (md_op == OP_DIV) || (md_op == OP_DIVU);
    is_mt    = (md_op == OP_MTHI) || (md_op == OP_MTLO);
    accept   = start & ~busy_q & is_md;
    mt_write = start & ~busy_q & is_mt;
  end

  // Last busy cycle: the counter steps 1 -> 0 on the coming edge.
  assign done = (cnt_q == CNT_W'(1));

  // ---------------- multiply datapath ----------------
  // Sign- or zero-extend to 2*WIDTH, then a plain 2*WIDTH product gives
  // the correct low 2*WIDTH bits for both signed and unsigned forms.
  logic                   mul_signed;
  logic [2*WIDTH-1:0]     ext_a, ext_b, prod, acc;

  assign mul_signed = (req_q.op == OP_MULT) || (req_q.op == OP_MADD) ||
                      (req_q.op == OP_MSUB);
  assign ext_a = mul_signed ? {{WIDTH{req_q.a[WIDTH-1]}}, req_q.a}
                            : {{WIDTH{1'b0}}, req_q.a};
  assign ext_b = mul_signed ? {{WIDTH{req_q.b[WIDTH-1]}}, req_q.b}
                            : {{WIDTH{1'b0}}, req_q.b};
  assign prod  = ext_a * ext_b;
  // Accumulate uses HI/LO as they stand at completion.
  assign acc   = {hi_q, lo_q};

  // ---------------- divide datapath ----------------
  // Signed divide runs on magnitudes; the quotient is negated when the
  // signs differ and the remainder follows the dividend. MIN / -1 falls
  // out naturally: |MIN| / 1 wraps back to MIN with a zero remainder.
  logic             div_signed, a_neg, b_neg, div_by_zero;
  logic [WIDTH-1:0] mag_a, mag_b, div_den, q_mag, r_mag, quot, rem;

  assign div_signed  = (req_q.op == OP_DIV);
  assign a_neg       = div_signed & req_q.a[WIDTH-1];
  assign b_neg       = div_signed & req_q.b[WIDTH-1];
  assign mag_a       = a_neg ? -req_q.a : req_q.a;
  assign mag_b       = b_neg ? -req_q.b : req_q.b;
  assign div_by_zero = (req_q.b == '0);
  // Keep the divider away from a zero denominator; the result is
  // discarded in that case anyway.
  assign div_den     = div_by_zero ? WIDTH'(1) : mag_b;
  assign q_mag       = mag_a / div_den;
  assign r_mag       = mag_a % div_den;
  assign quot        = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem         = a_neg ? -r_mag : r_mag;

  logic [WIDTH-1:0] res_hi, res_lo;

  // Result select for the latched op; a zero divisor leaves HI/LO alone.
  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    case (req_q.op)
      OP_MULT, OP_MULTU: {res_hi, res_lo} = prod;
      OP_MADD, OP_MADDU: {res_hi, res_lo} = acc + prod;
      OP_MSUB, OP_MSUBU: {res_hi, res_lo} = acc - prod;
      OP_DIV, OP_DIVU: begin
        if (!div_by_zero) begin
          res_hi = rem;
          res_lo = quot;
        end
      end
      default: ;
    endcase
  end

  // Issue latch and latency counter; busy mirrors counter != 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (accept) begin
      req_q  <= '{op: md_op, a: rs_data, b: rt_data};
      cnt_q  <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
      busy_q <= 1'b1;
    end else if (cnt_q != '0) begin
      cnt_q  <= cnt_q - CNT_W'(1);
      busy_q <= !done;
    end
  end

  // HI/LO: commit on the final countdown edge, or direct mthi/mtlo.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (done) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else if (mt_write) begin
      if (md_op == OP_MTHI) hi_q <= rs_data;
      else                  lo_q <= rs_data;
    end
  end

  assign busy      = busy_q;
  assign stall_req = busy_q | (start & is_md);
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Parametrised multiply/divide unit for the five-stage MIPS pipeline, placed in the E stage next to the ALU. It owns the HI/LO register pair and executes mult/multu/div/divu plus the accumulate forms madd/maddu/msub/msubu over a configurable number of cycles. It exposes a busy flag and a stall request so the D-stage hazard logic can hold HI/LO readers and new MD instructions while an operation is in flight.

## Interface

- WIDTH, 32, operand and HI/LO width
- MUL_CYCLES, 5, cycles busy after a mult-family start (≥1)
- DIV_CYCLES, 10, cycles busy after a div-family start (≥1)
- CNT_W, 8, counter width; must hold max(MUL_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  issue strobe for md_op, valid for one cycle
- md_op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 madd, 6 maddu, 7 msub, 8 msubu, 9 mthi, 10 mtlo; 11–15 treated as none
- rs_data  in  WIDTH  forwarded rs operand from E stage
- rt_data  in  WIDTH  forwarded rt operand from E stage
- busy  out  WIDTH-independent 1  operation in flight
- stall_req  out  1  busy | (start & md_op in 1..8); combinational
- hi_out  out  WIDTH  current HI register
- lo_out  out  WIDTH  current LO register

## Operation

- Reset: HI=0, LO=0, counter=0, busy=0, latched operands/op=0. Applies immediately, including mid-operation. Any in-flight result is discarded.
- Start (md_op 1..8, start=1, busy=0): latch rs_data, rt_data, md_op; load counter with MUL_CYCLES (ops 1,2,5–8) or DIV_CYCLES (3,4).
- Counter decrements on each edge while non-zero. busy = (counter != 0), registered.
- On the edge where counter goes 1→0, HI/LO are written with the result computed from the latched operands.
- Results:
  - mult/multu: {HI,LO} = signed/unsigned 2·WIDTH product.
  - madd(u)/msub(u): {HI,LO} = {HI,LO} ± product. The HI/LO values used are those at completion. Wraps modulo 2^(2·WIDTH).
  - divu: LO = quotient, HI = remainder.
  - div: quotient truncated toward zero, remainder takes the dividend's sign. For MIN / −1: LO = MIN, HI = 0.
  - Divisor zero (div/divu): HI and LO unchanged; busy still lasts DIV_CYCLES.
- mthi/mtlo (start=1, busy=0): write rs_data to HI/LO on that edge. No busy cycle.
- Start of any op while busy=1: ignored, with no state change. The core guarantees this does not happen via stall_req; the bench checks that it is ignored.
- md_op none or start=0: no action.
- hi_out/lo_out are straight register outputs. Readers (mfhi/mflo) are stalled in D by the core while stall_req=1.

## Timing

- Cycle 0: start sampled at edge E0.
- busy is high in the N cycles following E0 (N = MUL_CYCLES or DIV_CYCLES).
- The new HI/LO are visible in the first cycle with busy=0, i.e. after edge E(N−1)+1 from E0. This is N edges after E0 in total.
- Back-to-back: a new start is accepted in the first cycle busy=0. There are no dead cycles.
- mthi/mtlo: value visible the cycle after the start edge.
- stall_req rises combinationally in cycle 0 and falls the cycle HI/LO update.
- Asynchronous reset asserted mid-operation: busy=0 and HI=LO=0 without waiting for a clock edge. The first edge after deassertion accepts a start.

## Test plan

- Signed mult, default params: rs=FFFFFFFD (−3), rt=5, mult → busy high exactly 5 cycles; then HI=FFFFFFFF, LO=FFFFFFF1.
- Division, default params:
  - divu 7/2 → after 10 cycles LO=3, HI=1.
  - div FFFFFFF9 (−7)/2 → LO=FFFFFFFD, HI=FFFFFFFF.
  - div 80000000/FFFFFFFF → LO=80000000, HI=0.
- Divide by zero and ignored starts:
  - Preset HI=AAAA0000, LO=0000BBBB via mthi/mtlo (visible after 1 cycle each).
  - divu x/0 → busy 10 cycles; HI/LO unchanged.
  - mult issued at cycle 3 of the divu → ignored.
- Accumulate:
  - HI=0, LO=FFFFFFFF, maddu 1·1 → HI=1, LO=0.
  - Then msub 2·3 → HI=0, LO=FFFFFFFA.
- Reset mid-op: start mult, assert reset at cycle 2 between edges → busy and HI/LO drop to 0 immediately. A new mult after release completes normally.
- Parametrised instance: WIDTH=16, MUL_CYCLES=1, DIV_CYCLES=3.
  - multu FFFF·FFFF → busy 1 cycle; HI=FFFE, LO=0001.
  - Back-to-back divu 10/3 accepted the next cycle → LO=3, HI=1 after 3 cycles.
